// File: rtl/bin_bcd_seq.sv
// rtl/bin_bcd_seq.sv - sequential W-bit binary to DIGITS-digit packed BCD converter (shift-add-3)
// Optional truncation flag output ovf when BIN_BCD_OVF_EN is defined.
module bin_bcd_seq #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BIN_BCD_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;

  logic [BW-1:0]   adj;
  logic [BW-1:0]   scr_next;
  logic            shifted_out;

  // Add-3 correction on every digit that would reach 10 or more after doubling.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    shifted_out = adj[BW-1];
    scr_next    = {adj[BW-2:0], sr_q[W-1]};
  end

`ifdef BIN_BCD_OVF_EN
  logic sticky_q, sticky_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
`ifdef BIN_BCD_OVF_EN
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = '0;
          cnt_d   = CW'(W);
          state_d = SHIFT;
`ifdef BIN_BCD_OVF_EN
          sticky_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
        scr_d = scr_next;
        sr_d  = {sr_q[W-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
`ifdef BIN_BCD_OVF_EN
        sticky_d = sticky_q | shifted_out;
`endif
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_next;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BIN_BCD_OVF_EN
          ovf_d = sticky_q | shifted_out;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

`ifdef BIN_BCD_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  // Bit leaving the scratch MSB is deliberately dropped when the flag is absent.
  logic unused_shifted_out;
  assign unused_shifted_out = shifted_out;
`endif

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// tb/tb_bin_bcd_seq.sv - scoreboard bench for bin_bcd_seq (DIGITS=2 and ovf checks when BIN_BCD_OVF_EN is defined)
module tb_bin_bcd_seq;

  localparam int W = 8;
`ifdef BIN_BCD_OVF_EN
  localparam int D = 2;
`else
  localparam int D = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     bin;
  logic             busy;
  logic             done;
  logic [4*D-1:0]   bcd;
`ifdef BIN_BCD_OVF_EN
  logic             ovf;
  logic             ovf_q[$];
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [4*D-1:0] exp_q[$];

  always #5 clk = ~clk;

  bin_bcd_seq #(.W(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef BIN_BCD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  function automatic logic [4*D-1:0] model_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v);
    int x;
    x = v;
    for (int i = 0; i < D; i++) x = x / 10;
    return (x != 0);
  endfunction

  // Drive start one cycle (called at #1 after an edge while the DUT is idle) and record the expectation.
  task automatic start_conv(input int v);
    bin   = W'(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(model_bcd(v));
`ifdef BIN_BCD_OVF_EN
    ovf_q.push_back(model_ovf(v));
`endif
  endtask

  task automatic wait_done(input int budget, output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        return;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++;
    if (bcd !== '0) begin miscompares++; $display("FAIL reset_bcd got %h want 0", bcd); end
`ifdef BIN_BCD_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_zero;
    int lat, bc;
    logic [4*D-1:0] e;
    start_conv(0);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL zero_busy_after_accept got %b want 1", busy); end
    wait_done(W + 4, lat, bc);
    bc = bc + 1;
    e = exp_q.pop_front();
`ifdef BIN_BCD_OVF_EN
    void'(ovf_q.pop_front());
`endif
    vectors++;
    if (lat !== W) begin miscompares++; $display("FAIL zero_latency got %0d want %0d", lat, W); end
    vectors++;
    if (bc !== W) begin miscompares++; $display("FAIL zero_busy_cycles got %0d want %0d", bc, W); end
    vectors++;
    if (bcd !== e) begin miscompares++; $display("FAIL zero_bcd got %h want %h", bcd, e); end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width got %b want 0", done); end
  endtask

  task automatic test_sweep;
    int lat, bc;
    logic [4*D-1:0] e;
    for (int v = 0; v < (1 << W); v++) begin
      start_conv(v);
      wait_done(W + 4, lat, bc);
      e = exp_q.pop_front();
      vectors++;
      if (lat !== W) begin miscompares++; $display("FAIL sweep_latency bin=%0d got %0d want %0d", v, lat, W); end
      vectors++;
      if (bcd !== e) begin miscompares++; $display("FAIL sweep_bcd bin=%0d got %h want %h", v, bcd, e); end
`ifdef BIN_BCD_OVF_EN
      begin
        logic eo;
        eo = ovf_q.pop_front();
        vectors++;
        if (ovf !== eo) begin miscompares++; $display("FAIL sweep_ovf bin=%0d got %b want %b", v, ovf, eo); end
      end
`endif
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL sweep_done_width bin=%0d got %b want 0", v, done); end
    end
  endtask

  task automatic test_spot;
    int spot_bin[5];
    logic [11:0] spot_exp[5];
    logic [11:0] full;
    logic [4*D-1:0] e;
    int lat, bc;
    spot_bin = '{9, 10, 15, 99, 255};
    spot_exp = '{12'h009, 12'h010, 12'h015, 12'h099, 12'h255};
    for (int i = 0; i < 5; i++) begin
      start_conv(spot_bin[i]);
      void'(exp_q.pop_front());
`ifdef BIN_BCD_OVF_EN
      void'(ovf_q.pop_front());
`endif
      full = spot_exp[i];
      e = full[4*D-1:0];
      wait_done(W + 4, lat, bc);
      vectors++;
      if (bcd !== e || lat !== W) begin
        miscompares++;
        $display("FAIL spot bin=%0d got %h lat %0d want %h lat %0d", spot_bin[i], bcd, lat, e, W);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ignore_busy;
    int lat, bc;
    logic [4*D-1:0] e;
    start_conv(123);
    bin   = W'(200);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = '0;
    wait_done(W + 4, lat, bc);
    e = exp_q.pop_front();
`ifdef BIN_BCD_OVF_EN
    void'(ovf_q.pop_front());
`endif
    vectors++;
    if (lat !== W - 1) begin miscompares++; $display("FAIL ignore_latency got %0d want %0d", lat, W - 1); end
    vectors++;
    if (bcd !== e) begin miscompares++; $display("FAIL ignore_bcd got %h want %h", bcd, e); end
    start_conv(200);
    wait_done(W + 4, lat, bc);
    e = exp_q.pop_front();
`ifdef BIN_BCD_OVF_EN
    void'(ovf_q.pop_front());
`endif
    vectors++;
    if (lat !== W) begin miscompares++; $display("FAIL done_cycle_start_latency got %0d want %0d", lat, W); end
    vectors++;
    if (bcd !== e) begin miscompares++; $display("FAIL done_cycle_start_bcd got %h want %h", bcd, e); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen;
    logic [4*D-1:0] e;
    start_conv(250);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
`ifdef BIN_BCD_OVF_EN
    ovf_q.delete();
`endif
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++;
    if (bcd !== '0) begin miscompares++; $display("FAIL abort_bcd got %h want 0", bcd); end
    seen = 0;
    for (int n = 0; n < W + 3; n++) begin
      if (done) seen++;
      @(posedge clk);
      #1;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL abort_done_pulses got %0d want 0", seen); end
    start_conv(7);
    wait_done(W + 4, lat, bc);
    e = exp_q.pop_front();
`ifdef BIN_BCD_OVF_EN
    void'(ovf_q.pop_front());
`endif
    vectors++;
    if (bcd !== e || lat !== W) begin
      miscompares++;
      $display("FAIL after_abort got %h lat %0d want %h lat %0d", bcd, lat, e, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int lat, bc, want;
    logic [4*D-1:0] e;
    bin   = W'(1);
    start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model_bcd(1));
`ifdef BIN_BCD_OVF_EN
    ovf_q.push_back(model_ovf(1));
`endif
    for (int j = 0; j < 3; j++) begin
      wait_done(W + 4, lat, bc);
      if (j < 2) begin
        bin = W'(j + 2);
        exp_q.push_back(model_bcd(j + 2));
`ifdef BIN_BCD_OVF_EN
        ovf_q.push_back(model_ovf(j + 2));
`endif
      end else begin
        start = 1'b0;
      end
      // Later conversions are measured from the previous done cycle, one cycle before their accept edge.
      want = (j == 0) ? W : W + 1;
      e = exp_q.pop_front();
`ifdef BIN_BCD_OVF_EN
      void'(ovf_q.pop_front());
`endif
      vectors++;
      if (lat !== want) begin miscompares++; $display("FAIL b2b_interval conv=%0d got %0d want %0d", j, lat, want); end
      vectors++;
      if (bcd !== e) begin miscompares++; $display("FAIL b2b_bcd conv=%0d got %h want %h", j, bcd, e); end
    end
    @(posedge clk);
    #1;
  endtask

`ifdef BIN_BCD_OVF_EN
  task automatic test_ovf;
    int vals[3];
    logic [7:0] eb[3];
    logic eo[3];
    int lat, bc;
    vals = '{255, 99, 100};
    eb   = '{8'h55, 8'h99, 8'h00};
    eo   = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      start_conv(vals[i]);
      void'(exp_q.pop_front());
      void'(ovf_q.pop_front());
      wait_done(W + 4, lat, bc);
      vectors++;
      if (bcd !== eb[i] || ovf !== eo[i]) begin
        miscompares++;
        $display("FAIL ovf_case bin=%0d got bcd %h ovf %b want bcd %h ovf %b", vals[i], bcd, ovf, eb[i], eo[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_zero();
    test_sweep();
    test_spot();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
`ifdef BIN_BCD_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
